// File: rtl/match_delay_pipe.sv
// match_delay_pipe
//   Multi-channel delay-matching pipeline with a run-time programmable delay.
//   Side-band data and a valid flag are delayed by exactly delay_cur enabled
//   cycles. This keeps them aligned with the results of variable-latency
//   arithmetic units.
//
// Ports
//   clk        : clock
//   reset_l    : asynchronous active-low reset
//   ce         : advance enable; 0 holds every stage and the in-flight count
//   flush      : clear all in-flight valid flags (data bits are kept)
//   delay_load : load min(delay_sel, MAX_DELAY) into delay_cur; implies flush
//   delay_sel  : requested delay
//   i_valid    : input sample valid
//   i          : input data, channel c in bits [c*WIDTH +: WIDTH]
//   o_valid    : delayed valid
//   o          : delayed data
//   delay_cur  : active delay
//   in_flight  : number of valid samples inside the active delay window
//   busy       : in_flight != 0
module match_delay_pipe #(
    parameter int WIDTH         = 1,
    parameter int CHANNELS      = 1,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 4,
    parameter int ZERO_INVALID  = 0,
    parameter int DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic                        clk,
    input  logic                        reset_l,
    input  logic                        ce,
    input  logic                        flush,
    input  logic                        delay_load,
    input  logic [DW-1:0]               delay_sel,
    input  logic                        i_valid,
    input  logic [CHANNELS*WIDTH-1:0]   i,
    output logic                        o_valid,
    output logic [CHANNELS*WIDTH-1:0]   o,
    output logic [DW-1:0]               delay_cur,
    output logic [DW-1:0]               in_flight,
    output logic                        busy
);

    localparam int DATA_W = CHANNELS * WIDTH;

    logic [DATA_W-1:0]    data_q [MAX_DELAY];
    logic [MAX_DELAY-1:0] vld_q;
    logic [MAX_DELAY-1:0] vld_d;
    logic [DW-1:0]        delay_cur_q;
    logic [DW-1:0]        delay_cur_d;
    logic [DW-1:0]        in_flight_q;
    logic [DW-1:0]        in_flight_d;

    logic                 flush_all;
    logic                 tap_vld;
    logic [DATA_W-1:0]    tap_data;
    logic                 out_vld;
    logic [DATA_W-1:0]    out_data;

    // A delay reload invalidates everything in flight, because the window changes.
    assign flush_all = flush | delay_load;

    // Tap select: stage[D-1] for D >= 1. D = 0 selects nothing, and the bypass covers that case.
    always_comb begin
        tap_vld  = 1'b0;
        tap_data = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (delay_cur_q == DW'(k + 1)) begin
                tap_vld  = vld_q[k];
                tap_data = data_q[k];
            end
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (flush_all) begin
            vld_d = '0;
        end else if (ce) begin
            vld_d[0] = i_valid;
            for (int k = 1; k < MAX_DELAY; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    // The count only moves on an advancing cycle with a non-zero window. A sample
    // entering and one leaving on the same edge cancel out.
    always_comb begin
        in_flight_d = in_flight_q;
        if (flush_all) begin
            in_flight_d = '0;
        end else if (ce && (delay_cur_q != '0)) begin
            in_flight_d = in_flight_q + {{(DW-1){1'b0}}, i_valid}
                                      - {{(DW-1){1'b0}}, tap_vld};
        end
    end

    always_comb begin
        delay_cur_d = delay_cur_q;
        if (delay_load) begin
            delay_cur_d = (delay_sel > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : delay_sel;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                data_q[k] <= '0;
            end
        end else if (ce) begin
            data_q[0] <= i;
            for (int k = 1; k < MAX_DELAY; k++) begin
                data_q[k] <= data_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            vld_q       <= '0;
            in_flight_q <= '0;
            delay_cur_q <= DW'(DEFAULT_DELAY);
        end else begin
            vld_q       <= vld_d;
            in_flight_q <= in_flight_d;
            delay_cur_q <= delay_cur_d;
        end
    end

    // With delay 0, the input passes straight through. A flush in the same cycle
    // suppresses the valid, the same way it drops the sample in the registered path.
    always_comb begin
        if (delay_cur_q == '0) begin
            out_vld  = i_valid & ~flush;
            out_data = i;
        end else begin
            out_vld  = tap_vld;
            out_data = tap_data;
        end
    end

    assign o_valid   = out_vld;
    assign o         = ((ZERO_INVALID != 0) && !out_vld) ? '0 : out_data;
    assign delay_cur = delay_cur_q;
    assign in_flight = in_flight_q;
    assign busy      = (in_flight_q != '0);

endmodule

// File: tb/tb_match_delay_pipe.sv
module tb_match_delay_pipe;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int MAXD     = 16;
    localparam int DW       = 5;
    localparam int DW_TOT   = WIDTH * CHANNELS;

    logic              clk = 1'b0;
    logic              reset_l;
    logic              ce;
    logic              flush;
    logic              delay_load;
    logic [DW-1:0]     delay_sel;
    logic              i_valid;
    logic [DW_TOT-1:0] i;
    logic              o_valid;
    logic [DW_TOT-1:0] o;
    logic [DW-1:0]     delay_cur;
    logic [DW-1:0]     in_flight;
    logic              busy;

    int checks = 0;
    int errors = 0;

    match_delay_pipe #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAXD),
        .DEFAULT_DELAY(4), .ZERO_INVALID(1)
    ) dut (
        .clk(clk), .reset_l(reset_l), .ce(ce), .flush(flush),
        .delay_load(delay_load), .delay_sel(delay_sel),
        .i_valid(i_valid), .i(i), .o_valid(o_valid), .o(o),
        .delay_cur(delay_cur), .in_flight(in_flight), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic c, input logic fl, input logic ld, input logic [DW-1:0] sel,
                       input logic iv, input logic [DW_TOT-1:0] d);
        @(negedge clk);
        ce = c; flush = fl; delay_load = ld; delay_sel = sel; i_valid = iv; i = d;
        #1;
    endtask

    initial begin
        reset_l = 1'b0; ce = 1'b0; flush = 1'b0; delay_load = 1'b0;
        delay_sel = '0; i_valid = 1'b0; i = '0;
        #12;
        chk("rst_ov", o_valid, 0);
        chk("rst_o", o, 0);
        chk("rst_dcur", delay_cur, 4);
        chk("rst_inf", in_flight, 0);
        chk("rst_busy", busy, 0);
        reset_l = 1'b1;

        // Single sample, D=4.
        cyc(1, 0, 0, 0, 1, 16'h0201);
        chk("t1_ov_c0", o_valid, 0);
        for (int c = 1; c <= 6; c++) begin
            cyc(1, 0, 0, 0, 0, 16'h0000);
            chk("t1_ov", o_valid, (c == 4));
            chk("t1_o", o, (c == 4) ? 16'h0201 : 16'h0000);
            chk("t1_inf", in_flight, (c >= 1 && c <= 4) ? 1 : 0);
        end

        // Stall for three cycles after the sample. The output moves to cycle 7.
        cyc(1, 0, 0, 0, 1, 16'h0A0B);
        for (int c = 1; c <= 8; c++) begin
            cyc(!(c >= 1 && c <= 3), 0, 0, 0, 0, 16'h0000);
            chk("t2_ov", o_valid, (c == 7));
            chk("t2_o", o, (c == 7) ? 16'h0A0B : 16'h0000);
            chk("t2_inf", in_flight, (c <= 7) ? 1 : 0);
        end

        // Continuous stream of counting data.
        for (int c = 0; c <= 9; c++) begin
            cyc(1, 0, 0, 0, 1, 16'(c + 16'h0100));
            chk("t3_inf", in_flight, (c < 4) ? c : 4);
            chk("t3_ov", o_valid, (c >= 4));
            chk("t3_o", o, (c >= 4) ? (c - 4 + 16'h0100) : 0);
        end
        cyc(1, 1, 0, 0, 0, 16'h0000);
        cyc(1, 0, 0, 0, 0, 16'h0000);
        chk("t3_cln_inf", in_flight, 0);

        // Flush with two samples in flight and a third arriving.
        cyc(1, 0, 0, 0, 1, 16'h1111);
        cyc(1, 0, 0, 0, 1, 16'h2222);
        cyc(1, 1, 0, 0, 1, 16'h3333);
        chk("t4_inf_pre", in_flight, 2);
        for (int c = 3; c <= 8; c++) begin
            cyc(1, 0, 0, 0, 0, 16'h0000);
            chk("t4_ov", o_valid, 0);
            if (c == 3) chk("t4_inf_post", in_flight, 0);
        end

        // Load an out-of-range delay while stalled. It clamps to 16 and flushes.
        cyc(1, 0, 0, 0, 1, 16'h7777);
        cyc(0, 0, 1, 5'd20, 0, 16'h0000);
        cyc(1, 0, 0, 0, 1, 16'hBEEF);
        chk("t5_dcur", delay_cur, 16);
        chk("t5_inf", in_flight, 0);
        chk("t5_busy", busy, 0);
        for (int c = 1; c <= 17; c++) begin
            cyc(1, 0, 0, 0, 0, 16'h0000);
            chk("t5_ov", o_valid, (c == 16));
            if (c == 16) chk("t5_o", o, 16'hBEEF);
        end

        // Delay 0: combinational bypass.
        cyc(1, 0, 1, 5'd0, 0, 16'h0000);
        cyc(1, 0, 0, 0, 1, 16'h5A5A);
        chk("t6_dcur", delay_cur, 0);
        chk("t6_ov", o_valid, 1);
        chk("t6_o", o, 16'h5A5A);
        cyc(1, 0, 0, 0, 0, 16'h1234);
        chk("t6_inf", in_flight, 0);
        chk("t6_zi_ov", o_valid, 0);
        chk("t6_zi_o", o, 0);
        cyc(1, 1, 0, 0, 1, 16'h4321);
        chk("t6_fl_ov", o_valid, 0);
        chk("t6_fl_o", o, 0);

        // Asynchronous reset in the middle of operation, D=5.
        cyc(1, 0, 1, 5'd5, 0, 16'h0000);
        cyc(1, 0, 0, 0, 1, 16'hC0C0);
        cyc(1, 0, 0, 0, 0, 16'h0000);
        cyc(1, 0, 0, 0, 0, 16'h0000);
        cyc(1, 0, 0, 0, 1, 16'hC3C3);
        cyc(1, 0, 0, 0, 1, 16'hC4C4);
        cyc(0, 0, 0, 0, 0, 16'h0000);
        chk("t7_inf_pre", in_flight, 3);
        chk("t7_ov_pre", o_valid, 1);
        chk("t7_o_pre", o, 16'hC0C0);
        reset_l = 1'b0;
        #1;
        chk("t7_ov", o_valid, 0);
        chk("t7_o", o, 0);
        chk("t7_inf", in_flight, 0);
        chk("t7_dcur", delay_cur, 4);
        chk("t7_busy", busy, 0);
        cyc(0, 0, 0, 0, 0, 16'h0000);
        reset_l = 1'b1;
        cyc(0, 0, 0, 0, 0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
